// File: rtl/id_hazard_unit_pkg.sv
// Shared types for the decode-stage hazard unit.
// Shadow entries carry fixed-width fields wide enough for any sane RF_AW/STG_W.
package id_hazard_unit_pkg;

  localparam int MAX_AW = 8;
  localparam int MAX_SW = 4;

  localparam logic [MAX_SW-1:0] STG_EX  = 4'd1;
  localparam logic [MAX_SW-1:0] STG_MEM = 4'd2;
  localparam logic [MAX_SW-1:0] STG_WB  = 4'd3;

  typedef struct packed {
    logic              wen;
    logic [MAX_AW-1:0] rd;
    logic [MAX_SW-1:0] ready_stg;
    logic              is_long;
  } sh_entry_t;

endpackage

// File: rtl/hazard_src_check.sv
// Per-source priority match against the shadow pipeline.
// The youngest matching stage decides between forwarding and stalling.
module hazard_src_check
  import id_hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int RF_AW      = 5
)(
  input  logic                  rd_en_i,
  input  logic [RF_AW-1:0]      addr_i,
  input  logic                  busy_i,
  input  sh_entry_t             sh_i [NUM_STAGES],
  output logic [NUM_STAGES-1:0] fwd_o,
  output logic                  hazard_o
);

  logic [MAX_AW-1:0]     addr_x;
  logic                  live;
  logic                  hit;
  logic [NUM_STAGES-1:0] fwd;
  logic                  hz;

  assign addr_x = MAX_AW'(addr_i);
  assign live   = rd_en_i && (addr_i != '0);

  always_comb begin
    hit = 1'b0;
    fwd = '0;
    hz  = 1'b0;
    // Walk oldest to youngest so the youngest match overrides.
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (live && sh_i[i].wen && (sh_i[i].rd == addr_x)) begin
        hit = 1'b1;
        fwd = '0;
        hz  = 1'b0;
        if (!sh_i[i].is_long &&
            ((i + 1) >= int'(sh_i[i].ready_stg))) begin
          if (i < NUM_STAGES - 1)
            fwd[i] = 1'b1;
        end else begin
          hz = 1'b1;
        end
      end
    end
    if (live && !hit && busy_i)
      hz = 1'b1;
  end

  assign fwd_o    = fwd;
  assign hazard_o = hz;

endmodule

// File: rtl/id_hazard_unit.sv
// Decode-stage hazard detection, forwarding select and
// long-latency register scoreboard.
module id_hazard_unit
  import id_hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int RF_AW      = 5,
  parameter int NUM_REGS   = 2**RF_AW,
  parameter int STG_W      = $clog2(NUM_STAGES + 1)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [RF_AW-1:0]      id_rs1_addr,
  input  logic                  id_rs1_rd,
  input  logic [RF_AW-1:0]      id_rs2_addr,
  input  logic                  id_rs2_rd,
  input  logic [RF_AW-1:0]      id_rd_addr,
  input  logic                  id_reg_wen,
  input  logic [STG_W-1:0]      id_ready_stg,
  input  logic                  id_long,
  input  logic                  adv,
  input  logic [NUM_STAGES-1:0] flush_mask,
  input  logic                  id_flush,
  input  logic                  lr_done_valid,
  input  logic [RF_AW-1:0]      lr_done_rd,
  output logic                  hazard_stall,
  output logic                  issued,
  output logic [NUM_STAGES-1:0] fwd_rs1_sel,
  output logic [NUM_STAGES-1:0] fwd_rs2_sel,
  output logic [NUM_REGS-1:0]   sb_busy,
  output logic [31:0]           stall_cnt
);

  sh_entry_t sh_q [NUM_STAGES];
  sh_entry_t sh_f [NUM_STAGES];
  sh_entry_t sh_d [NUM_STAGES];
  sh_entry_t id_e;

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [NUM_STAGES-1:0] fwd1, fwd2;
  logic [NUM_STAGES-1:0] sel1_q, sel2_q;
  logic [31:0]           cnt_q;
  logic                  hz1, hz2, waw, live;

  hazard_src_check #(
    .NUM_STAGES(NUM_STAGES),
    .RF_AW     (RF_AW)
  ) u_rs1 (
    .rd_en_i (id_rs1_rd),
    .addr_i  (id_rs1_addr),
    .busy_i  (busy_q[id_rs1_addr]),
    .sh_i    (sh_q),
    .fwd_o   (fwd1),
    .hazard_o(hz1)
  );

  hazard_src_check #(
    .NUM_STAGES(NUM_STAGES),
    .RF_AW     (RF_AW)
  ) u_rs2 (
    .rd_en_i (id_rs2_rd),
    .addr_i  (id_rs2_addr),
    .busy_i  (busy_q[id_rs2_addr]),
    .sh_i    (sh_q),
    .fwd_o   (fwd2),
    .hazard_o(hz2)
  );

  assign waw          = id_long & id_reg_wen & busy_q[id_rd_addr];
  assign live         = id_valid & ~id_flush;
  assign hazard_stall = live & (hz1 | hz2 | waw);
  assign issued       = live & ~hazard_stall & adv;

  always_comb begin
    id_e = '0;
    if (issued) begin
      id_e.wen       = id_reg_wen;
      id_e.rd        = MAX_AW'(id_rd_addr);
      id_e.ready_stg = MAX_SW'(id_ready_stg);
      id_e.is_long   = id_long;
    end
  end

  // Flush acts on pre-shift contents, then the shift (if any) moves them.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      sh_f[i] = sh_q[i];
      if (flush_mask[i])
        sh_f[i].wen = 1'b0;
    end
    for (int i = 0; i < NUM_STAGES; i++)
      sh_d[i] = sh_f[i];
    if (adv) begin
      sh_d[0] = id_e;
      for (int i = 1; i < NUM_STAGES; i++)
        sh_d[i] = sh_f[i-1];
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (lr_done_valid)
      busy_d[lr_done_rd] = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (flush_mask[i] && sh_q[i].wen && sh_q[i].is_long)
        busy_d[sh_q[i].rd[RF_AW-1:0]] = 1'b0;
    end
    if (issued && id_long && id_reg_wen && (id_rd_addr != '0))
      busy_d[id_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++)
        sh_q[i] <= '0;
      busy_q <= '0;
      sel1_q <= '0;
      sel2_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++)
        sh_q[i] <= sh_d[i];
      busy_q <= busy_d;
      if (issued) begin
        sel1_q <= fwd1;
        sel2_q <= fwd2;
      end
      if (hazard_stall && (cnt_q != '1))
        cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fwd_rs1_sel = sel1_q;
  assign fwd_rs2_sel = sel2_q;
  assign sb_busy     = busy_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit with an expectation queue
// drained against the DUT after each step.
module tb_id_hazard_unit;
  import id_hazard_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic        id_rs1_rd;
  logic [4:0]  id_rs2_addr;
  logic        id_rs2_rd;
  logic [4:0]  id_rd_addr;
  logic        id_reg_wen;
  logic [1:0]  id_ready_stg;
  logic        id_long;
  logic        adv;
  logic [2:0]  flush_mask;
  logic        id_flush;
  logic        lr_done_valid;
  logic [4:0]  lr_done_rd;
  logic        hazard_stall;
  logic        issued;
  logic [2:0]  fwd_rs1_sel;
  logic [2:0]  fwd_rs2_sel;
  logic [31:0] sb_busy;
  logic [31:0] stall_cnt;

  id_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs1_rd    (id_rs1_rd),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs2_rd    (id_rs2_rd),
    .id_rd_addr   (id_rd_addr),
    .id_reg_wen   (id_reg_wen),
    .id_ready_stg (id_ready_stg),
    .id_long      (id_long),
    .adv          (adv),
    .flush_mask   (flush_mask),
    .id_flush     (id_flush),
    .lr_done_valid(lr_done_valid),
    .lr_done_rd   (lr_done_rd),
    .hazard_stall (hazard_stall),
    .issued       (issued),
    .fwd_rs1_sel  (fwd_rs1_sel),
    .fwd_rs2_sel  (fwd_rs2_sel),
    .sb_busy      (sb_busy),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  task automatic expect_v(string t, logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] obs(string t);
    case (t)
      "stall":  return {31'd0, hazard_stall};
      "issued": return {31'd0, issued};
      "sel1":   return {29'd0, fwd_rs1_sel};
      "sel2":   return {29'd0, fwd_rs2_sel};
      "busy":   return sb_busy;
      "cnt":    return stall_cnt;
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.tag);
      checks++;
      assert (o === e.v) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid      = 1'b0;
    id_rs1_addr   = '0;
    id_rs1_rd     = 1'b0;
    id_rs2_addr   = '0;
    id_rs2_rd     = 1'b0;
    id_rd_addr    = '0;
    id_reg_wen    = 1'b0;
    id_ready_stg  = '0;
    id_long       = 1'b0;
    adv           = 1'b1;
    flush_mask    = '0;
    id_flush      = 1'b0;
    lr_done_valid = 1'b0;
    lr_done_rd    = '0;
  endtask

  task automatic instr(logic [4:0] r1, logic r1e,
                       logic [4:0] r2, logic r2e,
                       logic [4:0] rd, logic we,
                       logic [3:0] stg, logic lg);
    id_valid     = 1'b1;
    id_rs1_addr  = r1;
    id_rs1_rd    = r1e;
    id_rs2_addr  = r2;
    id_rs2_rd    = r2e;
    id_rd_addr   = rd;
    id_reg_wen   = we;
    id_ready_stg = stg[1:0];
    id_long      = lg;
  endtask

  task automatic clear_pipe();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) tick();
    #1;
    expect_v("stall", 0);
    expect_v("issued", 0);
    expect_v("sel1", 0);
    expect_v("sel2", 0);
    expect_v("busy", 0);
    expect_v("cnt", 0);
    drain();
    rst = 1'b0;
    tick();

    // ALU back-to-back
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, STG_EX, 1'b0);
    #1;
    expect_v("stall", 0);
    expect_v("issued", 1);
    drain();
    tick();
    instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, STG_EX, 1'b0);
    #1;
    expect_v("stall", 0);
    expect_v("issued", 1);
    drain();
    tick();
    expect_v("sel1", 32'h1);
    expect_v("sel2", 0);
    drain();

    // Load-use
    clear_pipe();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, STG_MEM, 1'b0);
    tick();
    instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, STG_EX, 1'b0);
    #1;
    expect_v("stall", 1);
    expect_v("issued", 0);
    drain();
    tick();
    exp_cnt++;
    expect_v("cnt", exp_cnt);
    expect_v("stall", 0);
    expect_v("issued", 1);
    drain();
    tick();
    expect_v("sel1", 32'h2);
    expect_v("sel2", 0);
    drain();

    // Long op through scoreboard
    clear_pipe();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, STG_WB, 1'b1);
    tick();
    expect_v("busy", 32'h80);
    drain();
    idle();
    instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, STG_EX, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_v("stall", 1);
      drain();
      tick();
      exp_cnt++;
    end
    lr_done_valid = 1'b1;
    lr_done_rd    = 5'd7;
    #1;
    expect_v("stall", 1);
    expect_v("busy", 32'h80);
    drain();
    tick();
    exp_cnt++;
    lr_done_valid = 1'b0;
    #1;
    expect_v("busy", 0);
    expect_v("stall", 0);
    expect_v("issued", 1);
    expect_v("cnt", exp_cnt);
    drain();
    tick();
    expect_v("sel1", 0);
    drain();

    // WAW block, then set-wins
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, STG_WB, 1'b1);
    tick();
    expect_v("busy", 32'h80);
    drain();
    lr_done_valid = 1'b1;
    lr_done_rd    = 5'd7;
    #1;
    expect_v("stall", 1);
    expect_v("issued", 0);
    drain();
    tick();
    exp_cnt++;
    lr_done_valid = 1'b0;
    #1;
    expect_v("busy", 0);
    expect_v("stall", 0);
    expect_v("issued", 1);
    drain();
    tick();
    expect_v("busy", 32'h80);
    drain();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, STG_WB, 1'b1);
    lr_done_valid = 1'b1;
    lr_done_rd    = 5'd10;
    #1;
    expect_v("issued", 1);
    drain();
    tick();
    expect_v("busy", 32'h480);
    drain();
    idle();
    lr_done_valid = 1'b1;
    lr_done_rd    = 5'd7;
    tick();
    lr_done_rd    = 5'd10;
    tick();
    expect_v("busy", 0);
    expect_v("cnt", exp_cnt);
    drain();

    // Flush of an ALU producer and of a long op
    clear_pipe();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, STG_EX, 1'b0);
    tick();
    idle();
    flush_mask = 3'b001;
    tick();
    idle();
    instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, STG_EX, 1'b0);
    #1;
    expect_v("stall", 0);
    expect_v("issued", 1);
    drain();
    tick();
    expect_v("sel1", 0);
    drain();
    clear_pipe();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, STG_WB, 1'b1);
    tick();
    expect_v("busy", 32'h800);
    drain();
    idle();
    adv        = 1'b0;
    flush_mask = 3'b001;
    tick();
    expect_v("busy", 0);
    drain();

    // Hold
    clear_pipe();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, STG_EX, 1'b0);
    tick();
    instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, STG_EX, 1'b0);
    tick();
    expect_v("sel1", 32'h1);
    drain();
    instr(5'd0, 1'b0, 5'd12, 1'b1, 5'd13, 1'b1, STG_EX, 1'b0);
    adv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_v("issued", 0);
      expect_v("stall", 0);
      drain();
      tick();
      expect_v("sel1", 32'h1);
      expect_v("sel2", 0);
      drain();
    end
    adv = 1'b1;
    #1;
    expect_v("issued", 1);
    drain();
    tick();
    expect_v("sel1", 0);
    expect_v("sel2", 32'h1);
    drain();

    // x0 never hazards or forwards
    clear_pipe();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, STG_MEM, 1'b0);
    tick();
    instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, STG_EX, 1'b0);
    #1;
    expect_v("stall", 0);
    expect_v("issued", 1);
    drain();
    tick();
    expect_v("sel1", 0);
    expect_v("sel2", 0);
    drain();

    // Reset mid-stall
    clear_pipe();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, STG_MEM, 1'b0);
    tick();
    instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, STG_EX, 1'b0);
    tick();
    exp_cnt++;
    tick();
    expect_v("sel1", 32'h2);
    expect_v("cnt", exp_cnt);
    drain();
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, STG_WB, 1'b1);
    tick();
    instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, STG_EX, 1'b0);
    #1;
    expect_v("stall", 1);
    expect_v("busy", 32'h80);
    drain();
    rst = 1'b1;
    tick();
    expect_v("stall", 0);
    expect_v("sel1", 0);
    expect_v("sel2", 0);
    expect_v("busy", 0);
    expect_v("cnt", 0);
    drain();
    rst = 1'b0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_unit.md
Name: id_hazard_unit

Overview:
- Parametrised hazard-detection and forwarding unit for the decode stage. It generalises the fixed EX/MEM/WB forwarding and the single load-use check to N shadow stages, each producer carrying a per-op "forwardable-from" stage.
- It adds a register scoreboard for long-latency ops (e.g. divider) that retire out of band.
- It sits beside the decoder in ID. It produces the stall request and the registered one-hot forward selects consumed by EX.

Parameters:
- NUM_STAGES, 3, number of downstream stages shadowed (stage 1 = EX … stage NUM_STAGES = WB).
- RF_AW, 5, register-address width.
- NUM_REGS, 32, scoreboard depth (2**RF_AW).
- STG_W, $clog2(NUM_STAGES+1), width of the ready-stage field.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  valid instruction in ID
- id_rs1_addr  in  RF_AW  rs1 index
- id_rs1_rd  in  1  instruction reads rs1
- id_rs2_addr  in  RF_AW  rs2 index
- id_rs2_rd  in  1  instruction reads rs2
- id_rd_addr  in  RF_AW  destination index
- id_reg_wen  in  1  instruction writes rd
- id_ready_stg  in  STG_W  first stage (1..NUM_STAGES) whose result is forwardable
- id_long  in  1  long-latency op; result returns via lr_done_*
- adv  in  1  pipeline advances this cycle (no downstream hold)
- flush_mask  in  NUM_STAGES  bit k-1 kills entry in stage k
- id_flush  in  1  kill instruction in ID
- lr_done_valid  in  1  long op writing back
- lr_done_rd  in  RF_AW  its rd
- hazard_stall  out  1  combinational stall request to HDU
- issued  out  1  combinational; instruction leaves ID this cycle
- fwd_rs1_sel  out  NUM_STAGES  registered one-hot forward select for EX (0 = regfile)
- fwd_rs2_sel  out  NUM_STAGES  same for rs2
- sb_busy  out  NUM_REGS  scoreboard state
- stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Reset: all shadow entries invalid (wen=0); sb_busy=0; fwd_*_sel=0; stall_cnt=0. Combinational outputs evaluate on the cleared state.
- Shadow entry k holds {wen, rd, ready_stg, long}.
- Match rule: source s matches stage k when id_rsX_rd & entry.wen & entry.rd==s & s!=0.
- Per source, the youngest matching stage (lowest k) decides:
  - k >= entry.ready_stg and !entry.long: forward from k.
  - otherwise: hazard.
- No match but sb_busy[s] & s!=0: hazard.
- WAW guard: id_long & id_reg_wen & sb_busy[id_rd_addr]: hazard.
- Stall and issue equations:
  - hazard_stall = id_valid & ~id_flush & (any hazard).
  - issued = id_valid & ~id_flush & ~hazard_stall & adv.
- On a clk edge with adv=1:
  - Stage 1 loads the ID fields with wen=id_reg_wen&issued (all fields zeroed if not issued).
  - Stage k loads stage k-1.
  - The stage NUM_STAGES entry is dropped.
- Flush is applied to the pre-shift contents. An entry in a flushed stage propagates with wen=0. Flush takes effect even when adv=0: wen is cleared in place.
- When adv=0 and no flush, the shadow holds.
- fwd_rsX_sel updates only when issued: one-hot of the forward stage, else 0. Otherwise it holds its value.
- Forward stage indexing is relative to the post-shift pipeline: a match in stage k yields sel bit k (EX sees the producer one stage further on). A match in stage NUM_STAGES is therefore not forwarded; the regfile is write-through and supplies it, so sel=0.
- Scoreboard:
  - Set busy[id_rd_addr] when issued & id_long & id_reg_wen & id_rd_addr!=0.
  - Clear busy[lr_done_rd] on lr_done_valid.
  - Clear busy[entry.rd] when a long entry is flushed.
  - Set and clear of the same index in one cycle: set wins.
  - busy[0] is never set.
- stall_cnt increments when hazard_stall=1 and saturates at 2**32-1.
- Reset asserted mid-operation clears everything on that edge. issued is ignored during rst.

Decomposition:
- Shared core package holds:
  - the shadow-entry struct (wen, rd, ready_stg, long);
  - ready-stage constants (STG_EX=1, STG_MEM=2, STG_WB=3).
- One sub-module, hazard_src_check: per-source priority match returning fwd one-hot and hazard. It is instantiated twice (rs1, rs2).

Test Plan:
- ALU back-to-back: add x5 (ready_stg=1), then sub x6,x5,x1 with adv=1 -> no stall; fwd_rs1_sel=3'b001 after the second issue.
- Load-use: lw x5 (ready_stg=2), next reads x5 -> hazard_stall=1 for 1 cycle, stall_cnt=1; then issue with fwd_rs1_sel=3'b010.
- Long op: div x7 id_long=1 -> sb_busy[7]=1; reader of x7 stalls until lr_done_valid with rd=7; it issues the cycle after, fwd=0. Simultaneous issue of a new div x7 with done of x7 is blocked by WAW; set-wins is checked with a different-source issue-plus-done.
- Flush: x5 producer in stage 1, flush_mask=3'b001 -> next reader of x5 issues with no stall and fwd=0. A flushed long op clears its sb_busy bit.
- Hold: adv=0 for 3 cycles with an ALU producer in stage 1 -> shadow is frozen, issued=0, fwd selects are unchanged.
- x0 and reset: producer rd=x0, reader of x0 -> no stall, fwd=0. rst mid-stall -> all outputs 0 on the next cycle.
